// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
// Owner encoding is used both for the in-flight owner and for the round-robin history.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic ARB_OWNER_IF = 1'b0;
    localparam logic ARB_OWNER_DM = 1'b1;

    // On conflict the side that was not granted last wins; a lone request always wins.
    function automatic logic rr_pick(input logic req_if, input logic req_dm, input logic last_gnt);
        logic pick;
        if (req_if && req_dm) begin
            pick = ~last_gnt;
        end else if (req_dm) begin
            pick = ARB_OWNER_DM;
        end else begin
            pick = ARB_OWNER_IF;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter with zero flag that times the fixed memory latency.
// It saturates at zero, so it only restarts through an explicit load.
module mem_lat_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch and data access.
// Round-robin on conflict; produces the pipeline stall for the control unit.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,

    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic                  dm_addr_mode,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_valid,
    output logic [DATA_WIDTH-1:0] dm_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic                  mem_addr_mode,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  stall,
    output arb_state_e            dbg_state
);

    // Handshake: a requester raises req with its payload and holds both until its
    // valid pulse; gnt pulses in the accept cycle, valid exactly MEM_LATENCY cycles later.

    localparam int unsigned      CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_e state_q;
    logic       owner_q;
    logic       owner_we_q;
    logic       last_gnt_q;

    logic       winner;
    logic       win_dm;
    logic       accept;
    logic       done;
    logic       cnt_zero;

    assign winner = rr_pick(if_req, dm_req, last_gnt_q);
    assign win_dm = (winner == ARB_OWNER_DM);

    // Reset masks both the accept and the completion so every output is quiet during reset.
    assign accept = ~rst & (state_q == ARB_IDLE) & (if_req | dm_req);
    assign done   = ~rst & (state_q == ARB_BUSY) & cnt_zero;

    mem_lat_counter #(
        .WIDTH (CNT_W)
    ) u_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i (CNT_LOAD),
        .dec_i      (state_q == ARB_BUSY),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= ARB_OWNER_IF;
            owner_we_q <= 1'b0;
            last_gnt_q <= ARB_OWNER_IF;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (accept) begin
                        state_q    <= ARB_BUSY;
                        owner_q    <= winner;
                        owner_we_q <= win_dm & dm_we;
                        last_gnt_q <= winner;
                    end
                end
                ARB_BUSY: begin
                    if (cnt_zero) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign if_gnt   = accept & ~win_dm;
    assign dm_gnt   = accept &  win_dm;
    assign if_valid = done & (owner_q == ARB_OWNER_IF);
    assign dm_valid = done & (owner_q == ARB_OWNER_DM);

    assign if_rdata = if_valid ? mem_rdata : '0;
    assign dm_rdata = (dm_valid & ~owner_we_q) ? mem_rdata : '0;

    // Memory side is driven straight from the winner in the accept cycle only.
    assign mem_en        = accept;
    assign mem_we        = dm_gnt & dm_we;
    assign mem_addr_mode = dm_gnt & dm_addr_mode;
    assign mem_addr      = if_gnt ? if_addr : (dm_gnt ? dm_addr : '0);
    assign mem_wdata     = (dm_gnt & dm_we) ? dm_wdata : '0;

    assign stall     = ~rst & ((if_req & ~if_valid) | (dm_req & ~dm_valid));
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: latency-2 instance for most scenarios,
// latency-1 instance for back-to-back fetches, with a delayed-read memory model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic        dm_addr_mode;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic        mem_addr_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall;
    arb_state_e  dbg_state;

    logic        b_if_req;
    logic [31:0] b_if_addr;
    logic        b_if_gnt;
    logic        b_if_valid;
    logic [31:0] b_if_rdata;
    logic        b_dm_req;
    logic        b_dm_we;
    logic        b_dm_addr_mode;
    logic [31:0] b_dm_addr;
    logic [31:0] b_dm_wdata;
    logic        b_dm_gnt;
    logic        b_dm_valid;
    logic [31:0] b_dm_rdata;
    logic        b_mem_en;
    logic        b_mem_we;
    logic        b_mem_addr_mode;
    logic [31:0] b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [31:0] b_mem_rdata;
    logic        b_stall;
    arb_state_e  b_dbg_state;

    int          checks;
    int          errors;
    logic [31:0] if_exp_q[$];
    logic [31:0] dm_exp_q[$];
    logic [31:0] b_exp_q[$];

    mem_port_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .MEM_LATENCY(2)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_valid     (if_valid),
        .if_rdata     (if_rdata),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr_mode (dm_addr_mode),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_gnt       (dm_gnt),
        .dm_valid     (dm_valid),
        .dm_rdata     (dm_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr_mode(mem_addr_mode),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .stall        (stall),
        .dbg_state    (dbg_state)
    );

    mem_port_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .MEM_LATENCY(1)
    ) u_dut_lat1 (
        .clk          (clk),
        .rst          (rst),
        .if_req       (b_if_req),
        .if_addr      (b_if_addr),
        .if_gnt       (b_if_gnt),
        .if_valid     (b_if_valid),
        .if_rdata     (b_if_rdata),
        .dm_req       (b_dm_req),
        .dm_we        (b_dm_we),
        .dm_addr_mode (b_dm_addr_mode),
        .dm_addr      (b_dm_addr),
        .dm_wdata     (b_dm_wdata),
        .dm_gnt       (b_dm_gnt),
        .dm_valid     (b_dm_valid),
        .dm_rdata     (b_dm_rdata),
        .mem_en       (b_mem_en),
        .mem_we       (b_mem_we),
        .mem_addr_mode(b_mem_addr_mode),
        .mem_addr     (b_mem_addr),
        .mem_wdata    (b_mem_wdata),
        .mem_rdata    (b_mem_rdata),
        .stall        (b_stall),
        .dbg_state    (b_dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // Memory content: a fixed instruction at 0x100, address-derived words elsewhere.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        logic [31:0] d;
        if (a == 32'h0000_0100) d = 32'h0050_0093;
        else d = {a[15:0], ~a[15:0]};
        return d;
    endfunction

    logic [31:0] pipe1, pipe2, b_pipe1;
    always @(posedge clk) begin
        pipe1   <= mem_en ? mem_model(mem_addr) : 32'hDEAD_BEEF;
        pipe2   <= pipe1;
        b_pipe1 <= b_mem_en ? mem_model(b_mem_addr) : 32'hDEAD_BEEF;
    end
    assign mem_rdata   = pipe2;
    assign b_mem_rdata = b_pipe1;

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr_mode = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h55;
        b_if_req = 1'b1; b_if_addr = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({if_gnt, dm_gnt, if_valid, dm_valid, mem_en, mem_we, mem_addr_mode, stall} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 00000000",
                     {if_gnt, dm_gnt, if_valid, dm_valid, mem_en, mem_we, mem_addr_mode, stall});
        end
        checks++;
        if ((mem_addr | mem_wdata | if_rdata | dm_rdata) !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got addr=%h wdata=%h ird=%h drd=%h exp 0",
                     mem_addr, mem_wdata, if_rdata, dm_rdata);
        end
        checks++;
        if (dbg_state !== ARB_IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d exp %0d", dbg_state, ARB_IDLE);
        end
        checks++;
        if ({b_if_gnt, b_if_valid, b_dm_gnt, b_dm_valid, b_mem_en, b_mem_we, b_mem_addr_mode, b_stall} !== 8'b0
            || (b_mem_addr | b_mem_wdata | b_if_rdata | b_dm_rdata) !== 32'h0 || b_dbg_state !== ARB_IDLE) begin
            errors++;
            $display("FAIL reset_lat1 got gnt=%b en=%b stall=%b addr=%h exp all 0", b_if_gnt, b_mem_en, b_stall, b_mem_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_addr_mode = 1'b0; b_if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_gnt, dm_gnt, mem_en, stall} !== 4'b0 || dbg_state !== ARB_IDLE) begin
            errors++;
            $display("FAIL idle_after_reset got gnt=%b%b en=%b stall=%b st=%0d exp 0",
                     if_gnt, dm_gnt, mem_en, stall, dbg_state);
        end
    endtask

    task automatic test_lone_fetch();
        logic [31:0] exp;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h100;
        if_exp_q.push_back(32'h0050_0093);
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1 || dm_gnt !== 1'b0) begin
            errors++;
            $display("FAIL fetch_gnt got if=%b dm=%b exp if=1 dm=0", if_gnt, dm_gnt);
        end
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || stall !== 1'b1) begin
            errors++;
            $display("FAIL fetch_accept got en=%b we=%b addr=%h stall=%b exp 1 0 00000100 1",
                     mem_en, mem_we, mem_addr, stall);
        end
        @(negedge clk);
        checks++;
        if ({if_gnt, if_valid, mem_en, stall} !== 4'b0001 || mem_addr !== 32'h0 || dbg_state !== ARB_BUSY) begin
            errors++;
            $display("FAIL fetch_busy got gnt=%b v=%b en=%b stall=%b addr=%h exp 0 0 0 1 0",
                     if_gnt, if_valid, mem_en, stall, mem_addr);
        end
        @(negedge clk);
        if (if_exp_q.size() > 0) exp = if_exp_q.pop_front(); else exp = 'x;
        checks++;
        if (if_valid !== 1'b1 || if_rdata !== exp || stall !== 1'b0) begin
            errors++;
            $display("FAIL fetch_valid got v=%b rdata=%h stall=%b exp 1 %h 0", if_valid, if_rdata, stall, exp);
        end
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b0 || if_rdata !== 32'h0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL fetch_after got v=%b rdata=%h stall=%b exp 0 0 0", if_valid, if_rdata, stall);
        end
    endtask

    task automatic test_store();
        logic [31:0] exp;
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr_mode = 1'b1; dm_addr = 32'h2003; dm_wdata = 32'hAB;
        dm_exp_q.push_back(32'h0);
        @(negedge clk);
        checks++;
        if ({dm_gnt, mem_en, mem_we, mem_addr_mode} !== 4'b1111 || mem_addr !== 32'h2003 || mem_wdata !== 32'hAB) begin
            errors++;
            $display("FAIL store_accept got gnt=%b en=%b we=%b mode=%b addr=%h wd=%h exp 1 1 1 1 00002003 000000ab",
                     dm_gnt, mem_en, mem_we, mem_addr_mode, mem_addr, mem_wdata);
        end
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr_mode, dm_valid} !== 4'b0 || mem_wdata !== 32'h0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL store_busy got en=%b we=%b mode=%b v=%b wd=%h stall=%b exp 0 0 0 0 0 1",
                     mem_en, mem_we, mem_addr_mode, dm_valid, mem_wdata, stall);
        end
        @(negedge clk);
        if (dm_exp_q.size() > 0) exp = dm_exp_q.pop_front(); else exp = 'x;
        checks++;
        if (dm_valid !== 1'b1 || dm_rdata !== exp) begin
            errors++;
            $display("FAIL store_done got v=%b rdata=%h exp 1 %h", dm_valid, dm_rdata, exp);
        end
        @(posedge clk); #1;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr_mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] exp;
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2040;
        @(negedge clk);
        checks++;
        if (dm_gnt !== 1'b1) begin
            errors++;
            $display("FAIL abort_gnt got %b exp 1", dm_gnt);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({dm_valid, dm_gnt, if_gnt, mem_en, stall} !== 5'b0) begin
            errors++;
            $display("FAIL abort_t1 got v=%b gnt=%b en=%b stall=%b exp 0", dm_valid, dm_gnt, mem_en, stall);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({if_gnt, dm_gnt, if_valid, dm_valid, mem_en, mem_we, mem_addr_mode, stall} !== 8'b0
            || (mem_addr | mem_wdata | dm_rdata | if_rdata) !== 32'h0 || dbg_state !== ARB_IDLE) begin
            errors++;
            $display("FAIL abort_t2 got v=%b en=%b stall=%b addr=%h st=%0d exp all 0",
                     dm_valid, mem_en, stall, mem_addr, dbg_state);
        end
        @(posedge clk); #1;
        rst = 1'b0; dm_addr = 32'h2080;
        dm_exp_q.push_back(mem_model(32'h2080));
        @(negedge clk);
        checks++;
        if (dm_gnt !== 1'b1 || mem_addr !== 32'h2080) begin
            errors++;
            $display("FAIL abort_regnt got gnt=%b addr=%h exp 1 00002080", dm_gnt, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (dm_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_early_valid got %b exp 0", dm_valid);
        end
        @(negedge clk);
        if (dm_exp_q.size() > 0) exp = dm_exp_q.pop_front(); else exp = 'x;
        checks++;
        if (dm_valid !== 1'b1 || dm_rdata !== exp) begin
            errors++;
            $display("FAIL abort_reload got v=%b rdata=%h exp 1 %h", dm_valid, dm_rdata, exp);
        end
        @(posedge clk); #1;
        dm_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_conflict();
        int   g_cyc[$];
        logic g_who[$];
        int   exp_cyc[3] = '{0, 3, 6};
        logic exp_who[3] = '{ARB_OWNER_DM, ARB_OWNER_IF, ARB_OWNER_DM};
        logic s_ifv, s_dmv;
        logic [31:0] exp;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h200; if_exp_q.push_back(mem_model(32'h200));
        dm_req = 1'b1; dm_we = 1'b0; dm_addr_mode = 1'b0; dm_addr = 32'h3000; dm_exp_q.push_back(mem_model(32'h3000));
        for (int c = 0; c < 40 && (if_req || dm_req); c++) begin
            @(negedge clk);
            s_ifv = if_valid;
            s_dmv = dm_valid;
            if (if_gnt) begin g_cyc.push_back(c); g_who.push_back(ARB_OWNER_IF); end
            if (dm_gnt) begin g_cyc.push_back(c); g_who.push_back(ARB_OWNER_DM); end
            if (if_valid) begin
                if (if_exp_q.size() > 0) exp = if_exp_q.pop_front(); else exp = 'x;
                checks++;
                if (if_rdata !== exp) begin
                    errors++;
                    $display("FAIL conflict_if_data c=%0d got %h exp %h", c, if_rdata, exp);
                end
            end
            if (dm_valid) begin
                if (dm_exp_q.size() > 0) exp = dm_exp_q.pop_front(); else exp = 'x;
                checks++;
                if (dm_rdata !== exp) begin
                    errors++;
                    $display("FAIL conflict_dm_data c=%0d got %h exp %h", c, dm_rdata, exp);
                end
            end
            @(posedge clk); #1;
            if (s_ifv) begin
                if (c < 7) begin if_addr = if_addr + 32'h4; if_exp_q.push_back(mem_model(if_addr)); end
                else if_req = 1'b0;
            end
            if (s_dmv) begin
                if (c < 7) begin dm_addr = dm_addr + 32'h4; dm_exp_q.push_back(mem_model(dm_addr)); end
                else dm_req = 1'b0;
            end
        end
        checks++;
        if (if_req || dm_req || g_cyc.size() < 3) begin
            errors++;
            $display("FAIL conflict_progress got grants=%0d req=%b%b exp >=3 and 00", g_cyc.size(), if_req, dm_req);
            if_req = 1'b0; dm_req = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (g_cyc[i] !== exp_cyc[i] || g_who[i] !== exp_who[i]) begin
                    errors++;
                    $display("FAIL conflict_order i=%0d got c=%0d who=%b exp c=%0d who=%b",
                             i, g_cyc[i], g_who[i], exp_cyc[i], exp_who[i]);
                end
            end
        end
    endtask

    task automatic test_fairness();
        int   if_start, dm_start, n_g;
        logic prev_who;
        logic s_ifv, s_dmv;
        logic [31:0] exp;
        n_g = 0; prev_who = ARB_OWNER_DM; if_start = 0; dm_start = 0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h400; if_exp_q.push_back(mem_model(32'h400));
        for (int c = 0; c < 60 && (if_req || dm_req); c++) begin
            @(negedge clk);
            s_ifv = if_valid;
            s_dmv = dm_valid;
            checks++;
            if (if_gnt && dm_gnt) begin
                errors++;
                $display("FAIL fair_onehot c=%0d got both gnt exp one", c);
            end
            if (if_gnt || dm_gnt) begin
                if (n_g > 0) begin
                    checks++;
                    if (dm_gnt === prev_who) begin
                        errors++;
                        $display("FAIL fair_alternate c=%0d got who=%b exp %b", c, dm_gnt, ~prev_who);
                    end
                end
                checks++;
                if ((if_gnt && (c - if_start) > 3) || (dm_gnt && (c - dm_start) > 3)) begin
                    errors++;
                    $display("FAIL fair_wait c=%0d got if=%0d dm=%0d exp <=3", c, c - if_start, c - dm_start);
                end
                prev_who = dm_gnt;
                n_g++;
            end
            if (if_valid) begin
                if (if_exp_q.size() > 0) exp = if_exp_q.pop_front(); else exp = 'x;
                checks++;
                if (if_rdata !== exp) begin
                    errors++;
                    $display("FAIL fair_if_data c=%0d got %h exp %h", c, if_rdata, exp);
                end
            end
            if (dm_valid) begin
                if (dm_exp_q.size() > 0) exp = dm_exp_q.pop_front(); else exp = 'x;
                checks++;
                if (dm_rdata !== exp) begin
                    errors++;
                    $display("FAIL fair_dm_data c=%0d got %h exp %h", c, dm_rdata, exp);
                end
            end
            @(posedge clk); #1;
            if (c == 0) begin
                dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h5000; dm_start = 1;
                dm_exp_q.push_back(mem_model(32'h5000));
            end
            if (s_ifv) begin
                if (c < 20) begin if_addr = if_addr + 32'h4; if_exp_q.push_back(mem_model(if_addr)); if_start = c + 1; end
                else if_req = 1'b0;
            end
            if (s_dmv) begin
                if (c < 20) begin dm_addr = dm_addr + 32'h8; dm_exp_q.push_back(mem_model(dm_addr)); dm_start = c + 1; end
                else dm_req = 1'b0;
            end
        end
        checks++;
        if (n_g !== 8 || if_req || dm_req) begin
            errors++;
            $display("FAIL fair_count got grants=%0d req=%b%b exp 8 and 00", n_g, if_req, dm_req);
            if_req = 1'b0; dm_req = 1'b0;
        end
    endtask

    task automatic test_lat1_back_to_back();
        int   g_cyc[$];
        int   exp_cyc[3] = '{0, 2, 4};
        int   last_g, issued;
        logic s_v;
        logic [31:0] exp;
        last_g = -10; issued = 1;
        @(posedge clk); #1;
        b_if_req = 1'b1; b_if_addr = 32'h0; b_exp_q.push_back(mem_model(32'h0));
        for (int c = 0; c < 20 && b_if_req; c++) begin
            @(negedge clk);
            s_v = b_if_valid;
            if (b_if_gnt) begin g_cyc.push_back(c); last_g = c; end
            if (b_if_valid) begin
                if (b_exp_q.size() > 0) exp = b_exp_q.pop_front(); else exp = 'x;
                checks++;
                if (b_if_rdata !== exp || c !== last_g + 1) begin
                    errors++;
                    $display("FAIL lat1_valid c=%0d got rdata=%h gnt_c=%0d exp %h gnt_c=%0d",
                             c, b_if_rdata, last_g, exp, c - 1);
                end
            end
            checks++;
            if (b_dm_gnt || b_dm_valid || (b_if_gnt && b_if_valid)) begin
                errors++;
                $display("FAIL lat1_overlap c=%0d got gnt=%b v=%b dm=%b%b exp no overlap",
                         c, b_if_gnt, b_if_valid, b_dm_gnt, b_dm_valid);
            end
            @(posedge clk); #1;
            if (s_v) begin
                if (issued < 3) begin
                    b_if_addr = b_if_addr + 32'h4; b_exp_q.push_back(mem_model(b_if_addr)); issued++;
                end else b_if_req = 1'b0;
            end
        end
        checks++;
        if (g_cyc.size() !== 3 || b_if_req) begin
            errors++;
            $display("FAIL lat1_count got %0d req=%b exp 3 0", g_cyc.size(), b_if_req);
            b_if_req = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (g_cyc[i] !== exp_cyc[i]) begin
                    errors++;
                    $display("FAIL lat1_gnt_cycle i=%0d got %0d exp %0d", i, g_cyc[i], exp_cyc[i]);
                end
            end
        end
    endtask

    task automatic report();
        checks++;
        if (if_exp_q.size() != 0 || dm_exp_q.size() != 0 || b_exp_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained got if=%0d dm=%0d b=%0d exp 0",
                     if_exp_q.size(), dm_exp_q.size(), b_exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr_mode = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        b_if_req = 1'b0; b_if_addr = 32'h0;
        b_dm_req = 1'b0; b_dm_we = 1'b0; b_dm_addr_mode = 1'b0; b_dm_addr = 32'h0; b_dm_wdata = 32'h0;
        test_reset();
        test_lone_fetch();
        test_store();
        test_reset_mid_load();
        test_conflict();
        test_fairness();
        test_lat1_back_to_back();
        report();
        $finish;
    end

endmodule
